// File: rtl/sprinkler_scheduler.sv
// Purpose : scans ASCII zone records in the schedule RAM and drives one valve enable per zone.
// Latency : K records plus a terminator take 10K+3 edges from scan_start to the DONE edge.
//           A table of MAX_RECORDS records takes 10*MAX_RECORDS+1 edges.
// Backpr. : scan_start while busy sets a single pending flag; extra requests merge into one rescan.
// Ports   : clk/rst_n; scan_start, cur_min in; ram_en/we/addr/din out, ram_dout in;
//           zone_on, busy, scan_done, fmt_err, rec_count out (all registered).
module sprinkler_scheduler #(
  parameter int BASE_ADDR   = 10,
  parameter int NUM_ZONES   = 4,
  parameter int MAX_RECORDS = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scan_start,
  input  logic [10:0]          cur_min,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [7:0]           ram_addr,
  output logic [31:0]          ram_din,
  input  logic [31:0]          ram_dout,
  output logic [NUM_ZONES-1:0] zone_on,
  output logic                 busy,
  output logic                 scan_done,
  output logic                 fmt_err,
  output logic [5:0]           rec_count
);

  localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] CAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [31:0] WORD_ZONE = 32'h7A6F6E65; // "zone"
  localparam logic [31:0] WORD_TO   = 32'h2020746F; // "  to"

  logic [1:0]           state;
  logic [2:0]           w_idx;     // word index within the current record
  logic [7:0]           rec_rd;    // records fully read this scan
  logic [10:0]          t;         // minute of day latched at scan start
  logic                 t_bad;
  logic                 rec_bad;   // current record already failed a check
  logic [ZW-1:0]        zone_idx;
  logic [10:0]          s_min;
  logic [NUM_ZONES-1:0] shadow;    // result being built; copied to zone_on only at DONE
  logic                 pending;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic all_digits(input logic [31:0] w);
    return is_digit(w[31:24]) && is_digit(w[23:16]) && is_digit(w[15:8]) && is_digit(w[7:0]);
  endfunction

  // Low nibble of an ASCII digit is its value.
  function automatic logic [6:0] two_dig(input logic [7:0] hi, input logic [7:0] lo);
    return 7'(hi[3:0]) * 7'd10 + 7'(lo[3:0]);
  endfunction

  function automatic logic [13:0] four_dig(input logic [31:0] w);
    return 14'(w[27:24]) * 14'd1000 + 14'(w[19:16]) * 14'd100
         + 14'(w[11:8]) * 14'd10 + 14'(w[3:0]);
  endfunction

  function automatic logic time_ok(input logic [31:0] w);
    return all_digits(w) && (two_dig(w[31:24], w[23:16]) <= 7'd23)
                         && (two_dig(w[15:8],  w[7:0])   <= 7'd59);
  endfunction

  function automatic logic [10:0] time_min(input logic [31:0] w);
    logic [12:0] m;
    m = 13'(two_dig(w[31:24], w[23:16])) * 13'd60 + 13'(two_dig(w[15:8], w[7:0]));
    return m[10:0];
  endfunction

  logic [13:0] zone_val;
  logic [10:0] e_min;
  logic        word_ok;
  logic        active;
  logic        last_rec;
  logic        cap_issue;
  logic        start_now;

  always_comb begin
    zone_val = four_dig(ram_dout);
    e_min    = time_min(ram_dout);
    word_ok  = 1'b1;
    case (w_idx)
      3'd1:    word_ok = all_digits(ram_dout) && (zone_val < 14'(NUM_ZONES));
      3'd2:    word_ok = time_ok(ram_dout);
      3'd3:    word_ok = (ram_dout == WORD_TO);
      3'd4:    word_ok = time_ok(ram_dout);
      default: word_ok = 1'b1;
    endcase
    // Empty window when start equals end; S>E wraps past midnight.
    active = 1'b0;
    if (s_min < e_min)      active = (t >= s_min) && (t < e_min);
    else if (s_min > e_min) active = (t >= s_min) || (t < e_min);
    last_rec  = (rec_rd == 8'(MAX_RECORDS - 1));
    // Capture of one word and issue of the next share an edge, except at table end.
    cap_issue = 1'b1;
    if (w_idx == 3'd0)      cap_issue = (ram_dout == WORD_ZONE);
    else if (w_idx == 3'd4) cap_issue = !last_rec;
    start_now = ((state == IDLE) && scan_start) || ((state == DONE) && (pending || scan_start));
  end

  assign ram_we  = 1'b0;
  assign ram_din = 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_idx     <= 3'd0;
      rec_rd    <= 8'd0;
      t         <= 11'd0;
      t_bad     <= 1'b0;
      rec_bad   <= 1'b0;
      zone_idx  <= '0;
      s_min     <= 11'd0;
      shadow    <= '0;
      pending   <= 1'b0;
      ram_en    <= 1'b0;
      ram_addr  <= 8'd0;
      zone_on   <= '0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
      fmt_err   <= 1'b0;
      rec_count <= 6'd0;
    end else begin
      scan_done <= 1'b0;
      if (scan_start && ((state == READ) || (state == CAP))) pending <= 1'b1;

      case (state)
        READ: begin
          ram_en <= 1'b0;
          state  <= CAP;
        end
        CAP: begin
          case (w_idx)
            3'd0: rec_bad <= 1'b0;
            3'd1: begin
              zone_idx <= ZW'(zone_val);
              if (!word_ok) begin rec_bad <= 1'b1; fmt_err <= 1'b1; end
            end
            3'd2: begin
              s_min <= e_min;
              if (!word_ok) begin rec_bad <= 1'b1; fmt_err <= 1'b1; end
            end
            3'd3: if (!word_ok) begin rec_bad <= 1'b1; fmt_err <= 1'b1; end
            default: begin
              rec_rd <= rec_rd + 8'd1;
              if (!rec_bad && word_ok) begin
                rec_count <= rec_count + 6'd1;
                if (active) shadow[zone_idx] <= 1'b1;
              end else begin
                fmt_err <= 1'b1;
              end
            end
          endcase
          if (cap_issue) begin
            ram_en   <= 1'b1;
            ram_addr <= ram_addr + 8'd1;
            w_idx    <= (w_idx == 3'd4) ? 3'd0 : w_idx + 3'd1;
            state    <= READ;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          zone_on   <= t_bad ? '0 : shadow;
          scan_done <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: ;
      endcase

      // Shared by a fresh request in IDLE and a pending rescan from DONE,
      // so busy stays high across back-to-back scans.
      if (start_now) begin
        t         <= cur_min;
        t_bad     <= (cur_min >= 11'd1440);
        fmt_err   <= (cur_min >= 11'd1440);
        shadow    <= '0;
        rec_count <= 6'd0;
        rec_rd    <= 8'd0;
        w_idx     <= 3'd0;
        pending   <= 1'b0;
        ram_addr  <= 8'(BASE_ADDR);
        ram_en    <= 1'b1;
        busy      <= 1'b1;
        state     <= READ;
      end
    end
  end

endmodule

// File: tb/tb_sprinkler_scheduler.sv
// Purpose : directed checks of sprinkler_scheduler against a behavioural RAM holding ASCII records.
// Latency : scan_done expected after edge 10K+3 for K records plus terminator.
// Backpr. : pending-request merge and mid-scan reset are exercised directly.
module tb_sprinkler_scheduler;

  localparam int BASE = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_start;
  logic [10:0] cur_min;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [3:0]  zone_on;
  logic        busy, scan_done, fmt_err;
  logic [5:0]  rec_count;

  logic [31:0] mem [0:127];
  int          n_cmp = 0;
  int          n_err = 0;
  int          max_addr = 0;
  int          n;

  sprinkler_scheduler #(.BASE_ADDR(BASE), .NUM_ZONES(4), .MAX_RECORDS(20)) dut (
    .clk(clk), .rst_n(rst_n), .scan_start(scan_start), .cur_min(cur_min),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .zone_on(zone_on), .busy(busy), .scan_done(scan_done),
    .fmt_err(fmt_err), .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem[ram_addr[6:0]];
      if (int'(ram_addr) > max_addr) max_addr <= int'(ram_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dig4(input int v);
    return {8'(48 + (v / 1000) % 10), 8'(48 + (v / 100) % 10),
            8'(48 + (v / 10) % 10),   8'(48 + v % 10)};
  endfunction

  task automatic put_rec(input int k, input int zone, input int s_hhmm, input int e_hhmm);
    mem[BASE + 5*k + 0] = 32'h7A6F6E65;
    mem[BASE + 5*k + 1] = dig4(zone);
    mem[BASE + 5*k + 2] = dig4(s_hhmm);
    mem[BASE + 5*k + 3] = 32'h2020746F;
    mem[BASE + 5*k + 4] = dig4(e_hhmm);
  endtask

  task automatic load_default();
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    put_rec(0, 0,  800,  900);
    put_rec(1, 1, 1000, 1100);
    put_rec(2, 2, 1200, 1300);
    put_rec(3, 3, 2300,  100);
  endtask

  // Leaves the bench at the falling edge after edge 0.
  task automatic start_scan(input int c);
    @(negedge clk);
    cur_min    = 11'(c);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  // Counts rising edges until scan_done is seen at a falling edge.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      edges++;
      if (scan_done) break;
    end
    chk("scan_done_seen", {31'd0, scan_done}, 32'd1);
  endtask

  task automatic scan_expect(input string tag, input int c, input logic [3:0] zones,
                             input int recs, input logic err);
    start_scan(c);
    wait_done(n);
    chk({tag, "_edges"}, n, 43);
    chk({tag, "_zone_on"}, {28'd0, zone_on}, {28'd0, zones});
    chk({tag, "_rec_count"}, {26'd0, rec_count}, 32'(recs));
    chk({tag, "_fmt_err"}, {31'd0, fmt_err}, {31'd0, err});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    rst_n      = 1'b0;
    scan_start = 1'b0;
    cur_min    = 11'd0;
    load_default();
    repeat (3) @(negedge clk);
    chk("rst_zone_on", {28'd0, zone_on}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_scan_done", {31'd0, scan_done}, 32'd0);
    chk("rst_fmt_err", {31'd0, fmt_err}, 32'd0);
    chk("rst_rec_count", {26'd0, rec_count}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    rst_n = 1'b1;

    scan_expect("t510",  510,  4'b0001, 4, 1'b0);
    chk("ram_we", {31'd0, ram_we}, 32'd0);
    chk("ram_din", ram_din, 32'd0);
    scan_expect("t540",  540,  4'b0000, 4, 1'b0);
    scan_expect("t480",  480,  4'b0001, 4, 1'b0);
    scan_expect("t30",   30,   4'b1000, 4, 1'b0);
    scan_expect("t1380", 1380, 4'b1000, 4, 1'b0);
    scan_expect("t60",   60,   4'b0000, 4, 1'b0);
    // Out-of-range time: would hit the wrapping zone 3 window, but result is forced to 0.
    scan_expect("t1500", 1500, 4'b0000, 4, 1'b1);

    // Corrupt zone word of record 2 ("00A2").
    mem[BASE + 11] = 32'h30304132;
    scan_expect("bad750",  750,  4'b0000, 3, 1'b1);
    scan_expect("bad1400", 1400, 4'b1000, 3, 1'b1);
    load_default();
    scan_expect("clean", 510, 4'b0001, 4, 1'b0);

    // Two requests mid-scan (edges 5 and 7) merge into one back-to-back rescan.
    start_scan(510);
    cur_min = 11'd30;
    repeat (4) @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    wait_done(n);
    chk("pend_first_edges", n, 36);
    chk("pend_first_zone_on", {28'd0, zone_on}, 32'b0001);
    chk("pend_busy_held", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("pend_second_edges", n, 43);
    chk("pend_second_zone_on", {28'd0, zone_on}, 32'b1000);
    chk("pend_second_busy", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (scan_done || busy) pulses++;
    end
    chk("pend_no_third", pulses, 0);

    // Asynchronous reset at edge 20 of a scan.
    start_scan(510);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_zone_on", {28'd0, zone_on}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("arst_ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("arst_rec_count", {26'd0, rec_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_idle_busy", {31'd0, busy}, 32'd0);
    scan_expect("post_rst", 510, 4'b0001, 4, 1'b0);

    // Full table of MAX_RECORDS records followed by one more valid record that must not be read.
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    for (int k = 0; k < 19; k++) put_rec(k, k % 4, 0, 1);
    put_rec(19, 2, 0, 2359);
    put_rec(20, 1, 0, 2359);
    start_scan(100);
    wait_done(n);
    chk("max_edges", n, 201);
    chk("max_zone_on", {28'd0, zone_on}, 32'b0100);
    chk("max_rec_count", {26'd0, rec_count}, 32'd20);
    chk("max_fmt_err", {31'd0, fmt_err}, 32'd0);
    chk("max_addr_bound", max_addr, BASE + 5*20 - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprinkler_scheduler.md
Name: sprinkler_scheduler

Overview:
- Periodically scans the zone schedule table in the 128x32 schedule RAM.
- Table format: 5-word ASCII records "zone", "000N", "HHMM", "  to", "HHMM", starting at BASE_ADDR.
- Compares each record's window against the current minute-of-day and drives one valve-enable bit per zone.
- Sits between the time-of-day counter and the valve drivers. It is the sole read master of the RAM port while a scan runs.

Parameters:
BASE_ADDR, 10, word address of the first record's "zone" word
NUM_ZONES, 4, number of valve outputs; valid zone numbers are 0..NUM_ZONES-1
MAX_RECORDS, 20, maximum records scanned (BASE_ADDR+5*MAX_RECORDS must be at most 128)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
scan_start  in  1  single-cycle request to scan the table
cur_min  in  11  current minute of day, 0..1439
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable, constant 0
ram_addr  out  8  RAM word address
ram_din  out  32  RAM write data, constant 0
ram_dout  in  32  RAM read data, valid on the edge after ram_en is sampled
zone_on  out  NUM_ZONES  valve enables; bit N drives zone N
busy  out  1  scan in progress
scan_done  out  1  one-cycle pulse when a scan ends
fmt_err  out  1  sticky format-error flag for the last scan
rec_count  out  6  number of valid records accepted in the last scan

Behaviour:
- Reset (asynchronous, active-low, from any state, including mid-scan):
  - zone_on=0, busy=0, scan_done=0, fmt_err=0, rec_count=0.
  - ram_en=0, ram_addr=0; any pending scan request is cleared.
- All outputs are registered.
- FSM states: IDLE, READ, CAP, DONE.
- IDLE:
  - On scan_start=1 at an edge (edge 0): latch cur_min into t, clear shadow zones, clear error and count.
  - Set ram_addr=BASE_ADDR, ram_en=1, busy=1, and go to READ.
- READ: set ram_en=0 at the next edge, go to CAP.
- CAP: capture ram_dout and act on word index w within the record (w=0..4):
  - Word w is issued at edge 2w and captured at edge 2w+2.
  - Capture of the next word coincides with issue of the word after it.
- Per-word checks:
  - w=0: word must equal "zone" (32'h7A6F6E65). On mismatch the table has ended: go to DONE.
  - w=1: must be four ASCII digits; value must be < NUM_ZONES.
  - w=2 and w=4: four ASCII digits; HH<=23 and MM<=59. Converted to minutes as HH*60+MM, 11 bits.
  - w=3: must equal "  to" (32'h2020746F).
  - Byte [31:24] is the first character. A digit is a byte in 8'h30..8'h39, with value = byte-8'h30.
- Failed check at w=1..4:
  - The record is rejected and fmt_err is set.
  - The remaining words of the record are still read, so the next record stays aligned at +5.
- Record evaluation after capturing w=4, for an accepted record with start S and end E:
  - S<E: active when S<=t<E.
  - S>E (crosses midnight): active when t>=S or t<E.
  - S==E: never active.
  - If active, OR 1 into shadow[N]. Overlapping records for one zone OR together. Increment rec_count.
- If MAX_RECORDS records have been read, go to DONE after the w=4 capture instead of issuing the next "zone" word.
- A latched t >= 1440 sets fmt_err, and the scan result is forced to all zeros.
- DONE (one cycle):
  - zone_on <= shadow (an atomic update; zone_on never changes mid-scan).
  - Pulse scan_done, set busy=0.
  - Then go to IDLE, or restart the scan immediately if a request is pending.
- Table ended by a terminator after K records: scan_done is high in the cycle after edge 10K+3.
- scan_start while busy: a single pending flag is latched and a rescan starts from DONE. Extra requests merge into that one pending scan.
- ram_addr never exceeds BASE_ADDR+5*MAX_RECORDS-1.

Test Plan:
- Default table (zones 0..3: 0800-0900, 1000-1100, 1200-1300, 2300-0100, then a zero word), cur_min=510 -> zone_on=4'b0001, rec_count=4, fmt_err=0, scan_done after edge 43.
- Same table, cur_min=540 (end is exclusive) -> zone_on=0. cur_min=480 -> zone_on=4'b0001.
- Midnight wrap: cur_min=30 -> zone_on=4'b1000. cur_min=1380 -> 4'b1000. cur_min=60 -> 0.
- Corrupt RAM[BASE_ADDR+11]="00A2", cur_min=750 -> zone_on=0, fmt_err=1, rec_count=3. The next record is still parsed: cur_min=1400 gives 4'b1000.
- Pulse scan_start at edge 5 of a running scan -> exactly one extra scan follows back-to-back, with busy held high between the two scans.
- Assert rst_n=0 at edge 20 of a scan -> all outputs 0 immediately. After release, a fresh scan with cur_min=510 gives 4'b0001.
